dbus_wb_bridge: RTL and testbench
=================================

// Module: dbus_wb_bridge
// PURPOSE
//   Downstream of the CPU memory stage. Takes the CPU data-bus request (addr/be/wr/rd) and runs one
//   Wishbone-classic transaction per request, with a bus timeout. Returns read data, busy and a
//   one-cycle ack to the core. Registered request path; one outstanding transaction, no pipelining.
// PARAMETERS
//   p_timeout    64   cycles in WAIT before abort; 0 = timeout disabled
//   p_err_rdata  32'h0  read data returned on wb_err or timeout
// PORTS
//   i_clk         in   1   global clock, rising edge
//   i_rst         in   1   synchronous reset, active high
//   dbus_addr     in   32  word address from the memory stage, bits [1:0] are 0
//   dbus_be       in   4   byte enables
//   dbus_wr_en    in   1   write request
//   dbus_wr_data  in   32  pre-aligned write data
//   dbus_rd_en    in   1   read request
//   dbus_rd_data  out  32  read data, valid with dbus_ack after a read
//   dbus_busy     out  1   bridge cannot accept a request
//   dbus_ack      out  1   one-cycle completion pulse
//   o_bus_err     out  1   one-cycle pulse with dbus_ack when the access failed (wb_err or timeout)
//   wb_adr_o      out  32  Wishbone address
//   wb_dat_o      out  32  Wishbone write data
//   wb_sel_o      out  4   Wishbone byte select
//   wb_we_o       out  1   Wishbone write enable
//   wb_cyc_o      out  1   Wishbone cycle
//   wb_stb_o      out  1   Wishbone strobe
//   wb_dat_i      in   32  Wishbone read data
//   wb_ack_i      in   1   Wishbone acknowledge
//   wb_err_i      in   1   Wishbone error
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0, including dbus_rd_data and wb_*_o. Timeout counter = 0.
//   FSM states: IDLE, WAIT, DONE.
//   IDLE: a request (wr_en|rd_en) is accepted on the same edge.
//     - addr, be and wr_data are latched. we = wr_en.
//     - wr_en && rd_en together: write only; the read is dropped.
//     - Next state WAIT, with cyc=stb=1 from the next cycle.
//   WAIT: cyc, stb, adr, sel, we and dat are held stable.
//     - wb_ack_i: capture wb_dat_i if the access is a read; go to DONE.
//     - wb_err_i: capture p_err_rdata if a read; flag err; go to DONE.
//     - Priority on the same cycle: ack > err > timeout.
//     - cyc and stb drop on the edge that leaves WAIT.
//   Timeout counter: cleared on entry to WAIT, increments each WAIT cycle.
//     - count == p_timeout-1 with no ack/err: abort as for wb_err.
//   DONE (one cycle): dbus_ack=1, o_bus_err=err flag, then IDLE.
//   dbus_rd_data: updated only by read completions; holds its value otherwise, including across writes.
//   dbus_busy = (state != IDLE). It is combinational from state, not from the inputs.
//   Requests presented while busy are ignored and not queued; the core re-presents them after ack.
//   Latency: request accepted at edge N, stb high in cycle N+1.
//     - Zero-wait slave acks in N+1, giving dbus_ack in cycle N+2.
//     - Each slave wait state adds 1.
//   wb_ack_i and wb_err_i outside WAIT: ignored.
//   Reset mid-transaction: cyc/stb deassert at that edge; no dbus_ack is issued.
// STRUCTURE
//   Package pck_dbus: dbus_state_e {IDLE,WAIT,DONE}; the timeout counter width
//     localparam = $clog2(p_timeout+1).
//   Sub-module: none. The timeout counter is inline.
// TESTING
//   Read at 0x100, slave acks 1 cycle after stb with 0xCAFEBABE
//     -> dbus_ack 3 cycles after the request, dbus_rd_data=0xCAFEBABE, o_bus_err=0.
//   Write 0x12345678, be=4'b0011, at 0x204, 3 wait states
//     -> wb_sel=0011 and wb_we=1 held 4 cycles; ack once; dbus_rd_data unchanged.
//   Slave never acks, p_timeout=8
//     -> stb held exactly 8 cycles; dbus_ack with o_bus_err=1 and rd_data=p_err_rdata.
//   wb_err_i and wb_ack_i in the same cycle -> treated as ack, o_bus_err=0.
//   Second request while busy, and wr_en+rd_en together
//     -> the second request produces no Wishbone cycle; the dual request is issued as a write.
//   i_rst asserted in WAIT -> cyc/stb=0 next cycle; no ack; a new request then completes normally.

Source files
------------

// File: rtl/dbus_wb_bridge_pkg.sv
// Shared types and helpers for the CPU data-bus to Wishbone-classic bridge.
//   dbus_state_e  : bridge FSM states (idle, waiting on the slave, completion)
//   tmo_cnt_width : width of the WAIT-state timeout counter for a given timeout
package pck_dbus;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dbus_state_e;

    localparam int unsigned DEF_TIMEOUT = 64;

    // $clog2(timeout+1) bits; a disabled timeout (0) still gets a 1-bit
    // counter so the register never collapses to zero width.
    function automatic int unsigned tmo_cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/dbus_wb_bridge.sv
// CPU data-bus to Wishbone-classic bridge with bus timeout.
// One request is accepted in IDLE, run as a single Wishbone cycle, and
// completed with a one-cycle dbus_ack (plus o_bus_err on failure).
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   dbus_addr/be/wr_en/wr_data/rd_en  request from the memory stage
//   dbus_rd_data, dbus_busy, dbus_ack, o_bus_err   response to the core
//   wb_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o          Wishbone master outputs
//   wb_dat_i/ack_i/err_i                           Wishbone slave responses
module dbus_wb_bridge
    import pck_dbus::*;
#(
    parameter int unsigned p_timeout   = DEF_TIMEOUT,
    parameter logic [31:0] p_err_rdata = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] dbus_addr,
    input  logic [3:0]  dbus_be,
    input  logic        dbus_wr_en,
    input  logic [31:0] dbus_wr_data,
    input  logic        dbus_rd_en,
    output logic [31:0] dbus_rd_data,
    output logic        dbus_busy,
    output logic        dbus_ack,
    output logic        o_bus_err,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int unsigned     CNT_W    = tmo_cnt_width(p_timeout);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(p_timeout - 1);
    localparam bit              TMO_EN   = (p_timeout != 0);

    dbus_state_e      state_reg, state_next;
    logic [31:0]      adr_reg, adr_next;
    logic [31:0]      dat_reg, dat_next;
    logic [3:0]       sel_reg, sel_next;
    logic             we_reg, we_next;
    logic             stb_reg, stb_next;     // drives both cyc and stb
    logic             err_reg, err_next;
    logic [31:0]      rd_data_reg, rd_data_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            adr_reg     <= '0;
            dat_reg     <= '0;
            sel_reg     <= '0;
            we_reg      <= 1'b0;
            stb_reg     <= 1'b0;
            err_reg     <= 1'b0;
            rd_data_reg <= '0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            adr_reg     <= adr_next;
            dat_reg     <= dat_next;
            sel_reg     <= sel_next;
            we_reg      <= we_next;
            stb_reg     <= stb_next;
            err_reg     <= err_next;
            rd_data_reg <= rd_data_next;
            cnt_reg     <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        adr_next     = adr_reg;
        dat_next     = dat_reg;
        sel_next     = sel_reg;
        we_next      = we_reg;
        stb_next     = stb_reg;
        err_next     = err_reg;
        rd_data_next = rd_data_reg;
        cnt_next     = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (dbus_wr_en || dbus_rd_en) begin
                    state_next = WAIT;
                    adr_next   = dbus_addr;
                    dat_next   = dbus_wr_data;
                    sel_next   = dbus_be;
                    // A simultaneous read is dropped: write wins.
                    we_next    = dbus_wr_en;
                    stb_next   = 1'b1;
                    err_next   = 1'b0;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg + 1'b1;
                // ack has priority over err, err over the timeout.
                if (wb_ack_i) begin
                    state_next = DONE;
                    stb_next   = 1'b0;
                    err_next   = 1'b0;
                    if (!we_reg) begin
                        rd_data_next = wb_dat_i;
                    end
                end else if (wb_err_i || (TMO_EN && (cnt_reg == CNT_LAST))) begin
                    state_next = DONE;
                    stb_next   = 1'b0;
                    err_next   = 1'b1;
                    if (!we_reg) begin
                        rd_data_next = p_err_rdata;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                stb_next   = 1'b0;
            end
        endcase
    end

    assign dbus_busy    = (state_reg != IDLE);
    assign dbus_ack     = (state_reg == DONE);
    assign o_bus_err    = (state_reg == DONE) && err_reg;
    assign dbus_rd_data = rd_data_reg;
    assign wb_adr_o     = adr_reg;
    assign wb_dat_o     = dat_reg;
    assign wb_sel_o     = sel_reg;
    assign wb_we_o      = we_reg;
    assign wb_cyc_o     = stb_reg;
    assign wb_stb_o     = stb_reg;

endmodule

// File: tb/tb_dbus_wb_bridge.sv
// Self-checking bench for dbus_wb_bridge: table of transactions against a
// scripted Wishbone slave, a response scoreboard, and hand-written sequences
// for busy requests, stray slave responses and reset during WAIT.
module tb_dbus_wb_bridge;

    localparam int          TMO  = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_0BAD;

    logic        clk;
    logic        i_rst;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic        dbus_wr_en;
    logic [31:0] dbus_wr_data;
    logic        dbus_rd_en;
    logic [31:0] dbus_rd_data;
    logic        dbus_busy;
    logic        dbus_ack;
    logic        o_bus_err;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    dbus_wb_bridge #(
        .p_timeout  (TMO),
        .p_err_rdata(ERRD)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .dbus_addr   (dbus_addr),
        .dbus_be     (dbus_be),
        .dbus_wr_en  (dbus_wr_en),
        .dbus_wr_data(dbus_wr_data),
        .dbus_rd_en  (dbus_rd_en),
        .dbus_rd_data(dbus_rd_data),
        .dbus_busy   (dbus_busy),
        .dbus_ack    (dbus_ack),
        .o_bus_err   (o_bus_err),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_o    (wb_sel_o),
        .wb_we_o     (wb_we_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- scripted slave + bus observer ----------------
    // resp: 0 ack, 1 err, 2 never respond, 3 ack and err together
    int          slv_wait  = 0;
    logic [1:0]  slv_resp  = 2'd0;
    logic [31:0] slv_data  = 32'h0;
    logic        stray_ack = 1'b0;
    logic        stray_err = 1'b0;

    int          stb_cnt   = 0;
    int          last_len  = 0;
    int          wb_cycles = 0;
    logic [31:0] obs_adr, obs_dat;
    logic [3:0]  obs_sel;
    logic        obs_we;
    logic        unstable  = 1'b0;

    always @(negedge clk) begin
        if (wb_cyc_o || wb_stb_o) begin
            if (stb_cnt == 0) begin
                wb_cycles++;
                obs_adr  = wb_adr_o;
                obs_dat  = wb_dat_o;
                obs_sel  = wb_sel_o;
                obs_we   = wb_we_o;
                unstable = 1'b0;
            end else if (wb_adr_o !== obs_adr || wb_dat_o !== obs_dat ||
                         wb_sel_o !== obs_sel || wb_we_o !== obs_we) begin
                unstable = 1'b1;
            end
            if (wb_cyc_o !== wb_stb_o) unstable = 1'b1;
            if (slv_resp != 2'd2 && stb_cnt == slv_wait) begin
                wb_ack_i = (slv_resp == 2'd0) || (slv_resp == 2'd3);
                wb_err_i = (slv_resp == 2'd1) || (slv_resp == 2'd3);
                wb_dat_i = slv_data;
            end else begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                wb_dat_i = ~slv_data;
            end
            stb_cnt++;
        end else begin
            if (stb_cnt != 0) last_len = stb_cnt;
            stb_cnt  = 0;
            wb_ack_i = stray_ack;
            wb_err_i = stray_err;
            wb_dat_i = 32'h0BAD_0BAD;
        end
    end

    // ---------------- scoreboard of completions ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } sb_t;

    sb_t sb_q[$];
    int  ack_count = 0;

    always @(negedge clk) begin
        sb_t e;
        if (dbus_ack === 1'b1) begin
            ack_count++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=ack rd_data=%0h required=no_ack", dbus_rd_data);
            end else begin
                e = sb_q.pop_front();
                chk("ack_rd_data", dbus_rd_data, e.rdata);
                chk("ack_bus_err", o_bus_err, e.err);
            end
        end
    end

    // ---------------- transaction table ----------------
    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          wait_n;
        logic [1:0]  resp;
        logic [31:0] sdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;   // negedges from request cycle to dbus_ack
        int          exp_stb;   // cycles stb is high
        logic        exp_we;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    task automatic clear_req();
        dbus_wr_en   = 1'b0;
        dbus_rd_en   = 1'b0;
        dbus_addr    = 32'h0;
        dbus_be      = 4'h0;
        dbus_wr_data = 32'h0;
    endtask

    task automatic run_vec(input vec_t v, input bit inject);
        int  k;
        int  cyc0;
        sb_t e;
        slv_wait = v.wait_n;
        slv_resp = v.resp;
        slv_data = v.sdata;
        @(negedge clk);
        chk("busy_before_req", dbus_busy, 1'b0);
        cyc0         = wb_cycles;
        dbus_addr    = v.addr;
        dbus_be      = v.be;
        dbus_wr_data = v.wdata;
        dbus_wr_en   = v.wr;
        dbus_rd_en   = v.rd;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb_q.push_back(e);
        @(negedge clk);
        clear_req();
        k = 1;
        while (dbus_ack !== 1'b1 && k < 40) begin
            if (inject && k == 2) begin
                chk("busy_in_wait", dbus_busy, 1'b1);
                dbus_addr    = 32'h0000_0F00;
                dbus_be      = 4'hF;
                dbus_wr_data = 32'h0000_0099;
                dbus_wr_en   = 1'b1;
            end else begin
                clear_req();
            end
            @(negedge clk);
            k++;
        end
        clear_req();
        chk("ack_latency", k, v.exp_lat);
        if (dbus_ack !== 1'b1) sb_q.delete();
        repeat (3) @(negedge clk);
        chk("stb_cycles", last_len, v.exp_stb);
        chk("wb_adr", obs_adr, v.addr);
        chk("wb_sel", obs_sel, v.be);
        chk("wb_we", obs_we, v.exp_we);
        if (v.exp_we) chk("wb_dat", obs_dat, v.wdata);
        chk("wb_stable", unstable, 1'b0);
        chk("wb_cycle_count", wb_cycles - cyc0, 1);
        chk("sb_drained", sb_q.size(), 0);
        chk("idle_after", dbus_busy, 1'b0);
        $display("txn addr=%08h wr=%0b rd=%0b lat=%0d rd_data=%08h checks=%0d failures=%0d",
                 v.addr, v.wr, v.rd, k, dbus_rd_data, checks, failures);
    endtask

    initial begin
        vec_t vb;
        int   a0;
        //              wr    rd    addr          be    wdata         w  resp  sdata         exp_rdata     err  lat stb we
        vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 4'hF, 32'h0000_0000, 1, 2'd0, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0, 3, 2, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0204, 4'h3, 32'h1234_5678, 3, 2'd0, 32'hFFFF_FFFF, 32'hCAFE_BABE, 1'b0, 5, 4, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0300, 4'hF, 32'h0000_0000, 0, 2'd0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 2, 1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0304, 4'hC, 32'h0000_0000, 2, 2'd1, 32'h7777_7777, ERRD,          1'b1, 4, 3, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0308, 4'hF, 32'h0000_0000, 1, 2'd0, 32'h55AA_55AA, 32'h55AA_55AA, 1'b0, 3, 2, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0400, 4'hF, 32'h0000_0000, 0, 2'd2, 32'h6666_6666, ERRD,          1'b1, 9, 8, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0500, 4'hF, 32'h0000_0000, 0, 2'd3, 32'h1357_2468, 32'h1357_2468, 1'b0, 2, 1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0600, 4'hF, 32'hA5A5_A5A5, 1, 2'd1, 32'hFFFF_FFFF, 32'h1357_2468, 1'b1, 3, 2, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 32'h0000_0700, 4'h1, 32'h0000_00EE, 0, 2'd0, 32'hFFFF_FFFF, 32'h1357_2468, 1'b0, 2, 1, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 32'h0000_0800, 4'hF, 32'h1111_1111, 0, 2'd2, 32'hFFFF_FFFF, 32'h1357_2468, 1'b1, 9, 8, 1'b1};

        i_rst    = 1'b1;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h0;
        clear_req();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", dbus_busy, 1'b0);
        chk("rst_ack", dbus_ack, 1'b0);
        chk("rst_bus_err", o_bus_err, 1'b0);
        chk("rst_rd_data", dbus_rd_data, 32'h0);
        chk("rst_cyc", wb_cyc_o, 1'b0);
        chk("rst_stb", wb_stb_o, 1'b0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_sel", wb_sel_o, 4'h0);
        chk("rst_we", wb_we_o, 1'b0);
        i_rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], 1'b0);
        end

        // Request presented while busy must neither start a cycle nor be queued
        vb = '{1'b0, 1'b1, 32'h0000_0A04, 4'hF, 32'h0, 3, 2'd0, 32'h8765_4321, 32'h8765_4321, 1'b0, 5, 4, 1'b0};
        run_vec(vb, 1'b1);

        // Slave responses outside WAIT are ignored
        a0 = ack_count;
        @(negedge clk);
        stray_ack = 1'b1;
        stray_err = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_busy", dbus_busy, 1'b0);
        end
        stray_ack = 1'b0;
        stray_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_ack_count", ack_count - a0, 0);
        chk("stray_rd_data", dbus_rd_data, 32'h8765_4321);

        // Reset while waiting on a silent slave
        slv_resp   = 2'd2;
        @(negedge clk);
        dbus_addr  = 32'h0000_0900;
        dbus_be    = 4'hF;
        dbus_rd_en = 1'b1;
        @(negedge clk);
        clear_req();
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", dbus_busy, 1'b1);
        chk("pre_rst_cyc", wb_cyc_o, 1'b1);
        a0    = ack_count;
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        chk("mid_rst_cyc", wb_cyc_o, 1'b0);
        chk("mid_rst_stb", wb_stb_o, 1'b0);
        chk("mid_rst_busy", dbus_busy, 1'b0);
        chk("mid_rst_rd_data", dbus_rd_data, 32'h0);
        repeat (12) @(negedge clk);
        chk("mid_rst_no_ack", ack_count - a0, 0);

        vb = '{1'b0, 1'b1, 32'h0000_0A00, 4'hF, 32'h0, 1, 2'd0, 32'h2468_ACE0, 32'h2468_ACE0, 1'b0, 3, 2, 1'b0};
        run_vec(vb, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
